pixel_packer: RTL and testbench

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer_pkg.sv | 29 ++
 rtl/pixel_fifo.sv | 58 +++++
 rtl/pixel_packer.sv | 118 +++++++++++
 tb/tb_pixel_packer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_packer_pkg.sv
// Shared definitions for the pixel packer: pixel width, FSM state encoding
// and the layout of one buffered byte (last flag + two packed pixels).
package pixel_packer_pkg;

  localparam int unsigned PIX_BITS  = 4;
  localparam int unsigned BYTE_BITS = 2 * PIX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                 last;
    logic [BYTE_BITS-1:0] data;
  } fifo_entry_t;

  // The first pixel of a pair occupies the upper nibble.
  function automatic fifo_entry_t pack_entry(input logic                last,
                                             input logic [PIX_BITS-1:0] hi,
                                             input logic [PIX_BITS-1:0] lo);
    fifo_entry_t e;
    e.last = last;
    e.data = {hi, lo};
    return e;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of packed bytes with count-based full/empty.
// The head entry reads as zero while empty so idle outputs stay quiet.
module pixel_fifo
  import pixel_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_fifo: DEPTH must be a power of two >= 2");
  end

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/pixel_packer.sv
// Requests pixels from the iteration engine one at a time, packs pairs of
// 4-bit pixels into bytes and buffers them for a ready/valid consumer.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIX_BITS   = pixel_packer_pkg::PIX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  engine_running,
  input  logic                  pix_valid,
  input  logic [PIX_BITS-1:0]   pix_data,
  input  logic                  pix_last,
  output logic                  req_run,
  output logic [2*PIX_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);

  state_t              state;
  state_t              state_next;
  logic                outstanding;
  logic                phase;
  logic [PIX_BITS-1:0] nibble;
  logic                accept;
  logic                push;
  logic                pop;
  logic                req_int;
  logic                done_int;
  logic                fifo_empty;
  logic                fifo_full;
  fifo_entry_t         push_entry;
  fifo_entry_t         head;

  // Pixels only count while a frame is running.
  assign accept = (state == ST_RUN) && pix_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_int    = 1'b0;
    done_int   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        // A stray pix_valid this cycle would otherwise race the new request.
        req_int = !engine_running && !outstanding && !fifo_full && !pix_valid;
        if (accept && pix_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
          done_int   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= 1'b0;
      phase       <= 1'b0;
      nibble      <= '0;
    end else begin
      if (req_int)        outstanding <= 1'b1;
      else if (pix_valid) outstanding <= 1'b0;

      if (accept) begin
        if (phase || pix_last) begin
          phase  <= 1'b0;
          nibble <= '0;
        end else begin
          phase  <= 1'b1;
          nibble <= pix_data;
        end
      end
    end
  end

  // A last pixel landing on the first half of a pair flushes with a zero low nibble.
  assign push       = accept && (phase || pix_last);
  assign push_entry = phase ? pack_entry(pix_last, nibble, pix_data)
                            : pack_entry(pix_last, pix_data, '0);

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid  = !fifo_empty && !reset;
  assign pop        = out_valid && out_ready;
  assign out_data   = reset ? '0 : head.data;
  assign out_last   = !reset && head.last;
  assign req_run    = req_int && !reset;
  assign busy       = (state != ST_IDLE) && !reset;
  assign frame_done = done_int && !reset;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench: a modelled engine answers req_run, packs expected bytes
// into a queue, and a consumer process compares each accepted byte.
module tb_pixel_packer;

  localparam int unsigned DEPTH   = 4;
  localparam int          ENG_LAT = 3;

  logic       clk = 1'b0;
  logic       reset, start, engine_running, pix_valid, pix_last;
  logic [3:0] pix_data;
  logic       req_run, out_valid, out_ready, out_last, busy, frame_done;
  logic [7:0] out_data;

  pixel_packer #(.FIFO_DEPTH(DEPTH), .PIX_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .engine_running(engine_running),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .req_run(req_run), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] pix_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, req_total = 0, fd_total = 0, pix_sent = 0, bytes_seen = 0;
  int eng_cnt = 0;
  bit eng_en = 1'b0, chk_lat = 1'b0, m_phase = 1'b0;
  logic [3:0] m_hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: answers each request after ENG_LAT cycles and predicts bytes.
  initial begin : engine
    logic [4:0] p;
    forever begin
      @(negedge clk);
      if (eng_en) begin
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        if (eng_cnt > 0) begin
          eng_cnt--;
          engine_running = (eng_cnt != 0);
          if (eng_cnt == 0) begin
            if (pix_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL engine_underrun: request with no pixel queued at cycle %0d", cyc);
            end else begin
              p = pix_q.pop_front();
              pix_valid = 1'b1;
              pix_data  = p[3:0];
              pix_last  = p[4];
              pix_sent++;
              if (!m_phase) begin
                if (p[4]) exp_q.push_back('{{p[3:0], 4'h0}, 1'b1, cyc});
                else begin m_hold = p[3:0]; m_phase = 1'b1; end
              end else begin
                exp_q.push_back('{{m_hold, p[3:0]}, p[4], cyc});
                m_phase = 1'b0;
              end
            end
          end
        end
        #1;
        if (req_run === 1'b1) begin
          checks++;
          if (eng_cnt != 0) begin
            errors++;
            $display("FAIL req_while_outstanding: req_run=1 with %0d cycles left, expected 0", eng_cnt);
          end
          eng_cnt = ENG_LAT;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk); #2;
      if (req_run === 1'b1)    req_total++;
      if (frame_done === 1'b1) fd_total++;
    end
  end

  initial begin : consumer
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        bytes_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h last %b, expected none", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL byte: got %h last %b, expected %h last %b", out_data, out_last, e.data, e.last);
          end
          if (chk_lat) begin
            checks++;
            if (cyc != e.cyc + 1) begin
              errors++;
              $display("FAIL out_valid_latency: seen at cycle %0d, expected %0d", cyc, e.cyc + 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int fd0 = fd_total;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #4;
      if (fd_total != fd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pix(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (pix_sent >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; engine_running = 1'b0;
    pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (req_run !== 1'b0)    begin errors++; $display("FAIL reset_req_run: got %b expected 0", req_run); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    checks++; if (req_run !== 1'b0)   begin errors++; $display("FAIL idle_req_run: got %b expected 0", req_run); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_first_byte();
    int r0, b0; bit ok;
    pix_q = '{5'h03, 5'h0A, 5'h05, 5'h1C};
    out_ready = 1'b1; chk_lat = 1'b1; eng_en = 1'b1;
    r0 = req_total; b0 = bytes_seen;
    pulse_start();
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_frame_timeout: frame_done=0 expected 1"); end
    repeat (2) @(negedge clk); #4;
    checks++; if (bytes_seen - b0 != 2) begin errors++; $display("FAIL first_bytes: got %0d expected 2", bytes_seen - b0); end
    checks++; if (req_total - r0 != 4)  begin errors++; $display("FAIL first_reqs: got %0d expected 4", req_total - r0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL first_leftover: got %0d expected 0", exp_q.size()); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL first_idle: busy %b expected 0", busy); end
    chk_lat = 1'b0;
  endtask

  task automatic test_odd_frame();
    int f0, b0; bit ok;
    pix_q = '{5'h01, 5'h02, 5'h1F};
    out_ready = 1'b1; chk_lat = 1'b1;
    f0 = fd_total; b0 = bytes_seen;
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL odd_frame_timeout: frame_done=0 expected 1"); end
    repeat (3) @(negedge clk); #4;
    checks++; if (fd_total - f0 != 1)   begin errors++; $display("FAIL odd_frame_done_cycles: got %0d expected 1", fd_total - f0); end
    checks++; if (bytes_seen - b0 != 2) begin errors++; $display("FAIL odd_bytes: got %0d expected 2", bytes_seen - b0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL odd_idle: busy %b expected 0", busy); end
    chk_lat = 1'b0;
  endtask

  task automatic test_backpressure();
    int r0, b0; bit ok; logic [7:0] hd; logic hl;
    pix_q.delete();
    for (int i = 0; i < 12; i++) pix_q.push_back({(i == 11), 4'(i + 3)});
    out_ready = 1'b0;
    r0 = req_total; b0 = bytes_seen;
    pulse_start();
    repeat (80) @(negedge clk);
    #2;
    checks++; if (req_total - r0 != 8) begin errors++; $display("FAIL full_reqs: got %0d expected 8", req_total - r0); end
    checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
    checks++; if (exp_q.size() != 4)   begin errors++; $display("FAIL full_queued: got %0d expected 4", exp_q.size()); end
    checks++;
    if (exp_q.size() > 0 && (out_data !== exp_q[0].data || out_last !== exp_q[0].last)) begin
      errors++; $display("FAIL stall_head: got %h expected %h", out_data, exp_q[0].data);
    end
    hd = out_data; hl = out_last;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      checks++;
      if (out_data !== hd || out_last !== hl || out_valid !== 1'b1 || req_run !== 1'b0) begin
        errors++;
        $display("FAIL stall_stable: data %h last %b valid %b req %b, expected %h %b 1 0",
                 out_data, out_last, out_valid, req_run, hd, hl);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    checks++; if (bytes_seen - b0 != 1) begin errors++; $display("FAIL single_pop: got %0d expected 1", bytes_seen - b0); end
    checks++; if (req_total - r0 != 10) begin errors++; $display("FAIL resume_reqs: got %0d expected 10", req_total - r0); end
    checks++; if (exp_q.size() != 4)    begin errors++; $display("FAIL refill_queued: got %0d expected 4", exp_q.size()); end
    out_ready = 1'b1;
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_frame_timeout: frame_done=0 expected 1"); end
    repeat (2) @(negedge clk); #4;
    checks++; if (bytes_seen - b0 != 6) begin errors++; $display("FAIL bp_bytes: got %0d expected 6", bytes_seen - b0); end
    checks++; if (req_total - r0 != 12) begin errors++; $display("FAIL bp_reqs: got %0d expected 12", req_total - r0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int f0, b0; bit ok;
    pix_q = '{5'h07, 5'h08, 5'h19};
    out_ready = 1'b1;
    f0 = fd_total;
    pulse_start();
    wait_pix(pix_sent + 1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_first_pixel_timeout: no pixel, expected 1"); end
    @(negedge clk); reset = 1'b1;
    pix_q.delete(); exp_q.delete(); m_phase = 1'b0; eng_cnt = 0; engine_running = 1'b0;
    #2;
    checks++;
    if (req_run !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 ||
        busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: req %b valid %b last %b data %h busy %b done %b, expected all 0",
               req_run, out_valid, out_last, out_data, busy, frame_done);
    end
    @(negedge clk); reset = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_reset: busy %b valid %b expected 0 0", busy, out_valid); end
    checks++; if (fd_total != f0) begin errors++; $display("FAIL mid_no_frame_done: got %0d expected 0", fd_total - f0); end
    pix_q = '{5'h09, 5'h14};
    b0 = bytes_seen;
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clean_frame_timeout: frame_done=0 expected 1"); end
    repeat (2) @(negedge clk); #4;
    checks++; if (bytes_seen - b0 != 1) begin errors++; $display("FAIL clean_bytes: got %0d expected 1", bytes_seen - b0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL clean_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_ignored();
    int r0, f0, b0; bit ok;
    eng_en = 1'b0; engine_running = 1'b0;
    r0 = req_total; b0 = bytes_seen;
    @(negedge clk); pix_valid = 1'b1; pix_data = 4'h5; pix_last = 1'b1;
    #2;
    checks++; if (req_run !== 1'b0) begin errors++; $display("FAIL idle_pix_req: got %b expected 0", req_run); end
    @(negedge clk); pix_valid = 1'b0; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || req_total != r0 || bytes_seen != b0) begin
      errors++;
      $display("FAIL idle_pix_ignored: busy %b valid %b reqs %0d bytes %0d, expected 0 0 0 0",
               busy, out_valid, req_total - r0, bytes_seen - b0);
    end
    pix_q = '{5'h06, 5'h07, 5'h08, 5'h19};
    eng_en = 1'b1; out_ready = 1'b1;
    f0 = fd_total;
    pulse_start();
    wait_pix(pix_sent + 1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_first_pixel_timeout: no pixel, expected 1"); end
    pulse_start();
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_frame_timeout: frame_done=0 expected 1"); end
    repeat (10) @(negedge clk); #4;
    checks++; if (fd_total - f0 != 1)   begin errors++; $display("FAIL busy_frame_done: got %0d expected 1", fd_total - f0); end
    checks++; if (bytes_seen - b0 != 2) begin errors++; $display("FAIL busy_bytes: got %0d expected 2", bytes_seen - b0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL busy_restart: busy %b expected 0", busy); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL busy_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_odd_frame();
    test_backpressure();
    test_reset_mid();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
